// File: rtl/eth_rx_hdr_parser.sv
// Splits a RX_SHIFT16 Avalon-ST frame into an L2 header record and a word-aligned L3 payload stream.
// Define ETH_RX_HDR_VLAN_EN to enable single 802.1Q tag stripping.
module eth_rx_hdr_parser #(
    parameter int unsigned MAX_FRAME_WORDS = 384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [1:0]  in_empty,
    input  logic        in_error,
    output logic [47:0] hdr_dst_mac,
    output logic [47:0] hdr_src_mac,
    output logic [15:0] hdr_ethertype,
    output logic [15:0] hdr_vlan_tci,
    output logic        hdr_vlan_valid,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [1:0]  out_empty,
    output logic        out_error,
    output logic [15:0] stat_runt_cnt,
    output logic [15:0] stat_trunc_cnt
);
    localparam int unsigned CW = $clog2(MAX_FRAME_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_HDR2,
        S_HDR3,
`ifdef ETH_RX_HDR_VLAN_EN
        S_VLAN,
`endif
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [47:0] dst_stg_q, dst_stg_d;
    logic [31:0] src_stg_q, src_stg_d;
    logic [47:0] hdr_dst_q, hdr_dst_d;
    logic [47:0] hdr_src_q, hdr_src_d;
    logic [15:0] hdr_type_q, hdr_type_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic [15:0] runt_q, runt_d;
    logic [15:0] trunc_q, trunc_d;
    logic        runt_inc, trunc_inc, trunc_now, hdr_gate;
`ifdef ETH_RX_HDR_VLAN_EN
    logic [15:0] src_lo_stg_q, src_lo_stg_d;
    logic [15:0] tci_q, tci_d;
    logic        vv_q, vv_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        dst_stg_d   = dst_stg_q;
        src_stg_d   = src_stg_q;
        hdr_dst_d   = hdr_dst_q;
        hdr_src_d   = hdr_src_q;
        hdr_type_d  = hdr_type_q;
        hdr_valid_d = hdr_valid_q && !hdr_ready;
        runt_inc    = 1'b0;
        trunc_inc   = 1'b0;
        trunc_now   = 1'b0;
        hdr_gate    = 1'b0;
`ifdef ETH_RX_HDR_VLAN_EN
        src_lo_stg_d = src_lo_stg_q;
        tci_d        = tci_q;
        vv_d         = vv_q;
`endif
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_empty = '0;
        out_error = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_sop) begin
                    dst_stg_d[47:32] = in_data[15:0];
                    cnt_d = CW'(1);
                    if (in_eop) runt_inc = 1'b1;
                    else        state_d  = S_HDR1;
                end
            end
            S_PAYLOAD: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_data;
                out_sop   = first_q;
                out_eop   = in_eop;
                out_empty = in_empty;
                out_error = in_error;
                trunc_now = !in_eop && (cnt_q == CW'(MAX_FRAME_WORDS - 1));
                if (trunc_now) begin
                    out_eop   = 1'b1;
                    out_error = 1'b1;
                    out_empty = '0;
                end
                if (in_valid && out_ready) begin
                    first_d = 1'b0;
                    cnt_d   = cnt_q + CW'(1);
                    if (trunc_now) begin
                        trunc_inc = 1'b1;
                        state_d   = S_DROP;
                    end else if (in_eop) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (in_valid && in_eop) state_d = S_IDLE;
            end
            default: begin
                // Header states; the last one stalls while a previous record is still pending
                hdr_gate = (state_q == S_HDR3);
`ifdef ETH_RX_HDR_VLAN_EN
                hdr_gate = hdr_gate || (state_q == S_VLAN);
`endif
                if (hdr_gate) in_ready = !hdr_valid_q;
                if (in_valid && in_ready) begin
                    if (in_sop) begin
                        runt_inc = 1'b1;
                        dst_stg_d[47:32] = in_data[15:0];
                        cnt_d   = CW'(1);
                        state_d = in_eop ? S_IDLE : S_HDR1;
                    end else if (in_eop) begin
                        runt_inc = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (state_q == S_HDR1) begin
                            dst_stg_d[31:0] = in_data;
                            state_d = S_HDR2;
                        end else if (state_q == S_HDR2) begin
                            src_stg_d = in_data;
                            state_d = S_HDR3;
`ifdef ETH_RX_HDR_VLAN_EN
                        end else if (state_q == S_HDR3 && in_data[15:0] == 16'h8100) begin
                            src_lo_stg_d = in_data[31:16];
                            state_d = S_VLAN;
                        end else if (state_q == S_VLAN) begin
                            hdr_dst_d   = dst_stg_q;
                            hdr_src_d   = {src_stg_q, src_lo_stg_q};
                            hdr_type_d  = in_data[15:0];
                            tci_d       = in_data[31:16];
                            vv_d        = 1'b1;
                            hdr_valid_d = 1'b1;
                            first_d     = 1'b1;
                            state_d     = S_PAYLOAD;
`endif
                        end else begin
                            hdr_dst_d   = dst_stg_q;
                            hdr_src_d   = {src_stg_q, in_data[31:16]};
                            hdr_type_d  = in_data[15:0];
`ifdef ETH_RX_HDR_VLAN_EN
                            tci_d       = '0;
                            vv_d        = 1'b0;
`endif
                            hdr_valid_d = 1'b1;
                            first_d     = 1'b1;
                            state_d     = S_PAYLOAD;
                        end
                    end
                end
            end
        endcase

        runt_d  = (runt_inc && runt_q != '1) ? runt_q + 16'd1 : runt_q;
        trunc_d = (trunc_inc && trunc_q != '1) ? trunc_q + 16'd1 : trunc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            dst_stg_q   <= '0;
            src_stg_q   <= '0;
            hdr_dst_q   <= '0;
            hdr_src_q   <= '0;
            hdr_type_q  <= '0;
            hdr_valid_q <= 1'b0;
            runt_q      <= '0;
            trunc_q     <= '0;
`ifdef ETH_RX_HDR_VLAN_EN
            src_lo_stg_q <= '0;
            tci_q        <= '0;
            vv_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            dst_stg_q   <= dst_stg_d;
            src_stg_q   <= src_stg_d;
            hdr_dst_q   <= hdr_dst_d;
            hdr_src_q   <= hdr_src_d;
            hdr_type_q  <= hdr_type_d;
            hdr_valid_q <= hdr_valid_d;
            runt_q      <= runt_d;
            trunc_q     <= trunc_d;
`ifdef ETH_RX_HDR_VLAN_EN
            src_lo_stg_q <= src_lo_stg_d;
            tci_q        <= tci_d;
            vv_q         <= vv_d;
`endif
        end
    end

    assign hdr_dst_mac    = hdr_dst_q;
    assign hdr_src_mac    = hdr_src_q;
    assign hdr_ethertype  = hdr_type_q;
    assign hdr_valid      = hdr_valid_q;
    assign stat_runt_cnt  = runt_q;
    assign stat_trunc_cnt = trunc_q;
`ifdef ETH_RX_HDR_VLAN_EN
    assign hdr_vlan_tci   = tci_q;
    assign hdr_vlan_valid = vv_q;
`else
    assign hdr_vlan_tci   = '0;
    assign hdr_vlan_valid = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// Scoreboard bench for eth_rx_hdr_parser: expected header records and payload beats are
// queued as frames are driven and compared against what the DUT hands over.
module tb_eth_rx_hdr_parser;
    localparam int unsigned MAX = 16;
    localparam logic [31:0] TAG_WORD = 32'h0064_86DD;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  em;
        logic        er;
    } beat_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        logic [15:0] tci;
        logic        vv;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_ready, in_sop, in_eop, in_error;
    logic [1:0]  in_empty;
    logic [47:0] hdr_dst_mac, hdr_src_mac;
    logic [15:0] hdr_ethertype, hdr_vlan_tci;
    logic        hdr_vlan_valid, hdr_valid, hdr_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_sop, out_eop, out_error;
    logic [1:0]  out_empty;
    logic [15:0] stat_runt_cnt, stat_trunc_cnt;

    beat_t exp_q[$], got_q[$];
    hdr_t  exp_hdr_q[$], got_hdr_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [15:0] exp_runt = 0;
    logic [15:0] exp_trunc = 0;
    logic tog_done;

    always #5 clk = ~clk;

    eth_rx_hdr_parser #(.MAX_FRAME_WORDS(MAX)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_error(in_error),
        .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac), .hdr_ethertype(hdr_ethertype),
        .hdr_vlan_tci(hdr_vlan_tci), .hdr_vlan_valid(hdr_vlan_valid),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty), .out_error(out_error),
        .stat_runt_cnt(stat_runt_cnt), .stat_trunc_cnt(stat_trunc_cnt)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready)
                got_q.push_back({out_data, out_sop, out_eop, out_empty, out_error});
            if (hdr_valid && hdr_ready)
                got_hdr_q.push_back({hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_vlan_tci, hdr_vlan_valid});
        end
    end

    task automatic put(input logic [31:0] d, input logic s, input logic e,
                       input logic [1:0] em, input logic er);
        int unsigned n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_data = d; in_sop = s; in_eop = e; in_empty = em; in_error = er; in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 2'b0; in_error = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL put_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                              input int unsigned npay, input logic [1:0] em, input logic er,
                              input logic [7:0] seed);
        logic [31:0] w[$];
        int unsigned hlen, total, last;
        beat_t b;
        hdr_t h;
        w.push_back({16'h0, dst[47:32]});
        w.push_back(dst[31:0]);
        w.push_back(src[47:16]);
        w.push_back({src[15:0], typ});
        for (int unsigned i = 0; i < npay; i++)
            w.push_back((i == 0 && typ == 16'h8100) ? TAG_WORD : {seed, 8'h5A, 16'(i)});
        hlen = 4;
`ifdef ETH_RX_HDR_VLAN_EN
        if (typ == 16'h8100) hlen = 5;
`endif
        total = w.size();
        if (total <= hlen) begin
            exp_runt++;
        end else begin
            h.dst = dst; h.src = src; h.typ = typ; h.tci = 16'h0; h.vv = 1'b0;
            if (hlen == 5) begin
                h.typ = w[4][15:0]; h.tci = w[4][31:16]; h.vv = 1'b1;
            end
            exp_hdr_q.push_back(h);
            last = (total > MAX) ? MAX : total;
            if (total > MAX) exp_trunc++;
            for (int unsigned i = hlen; i < last; i++) begin
                b.d  = w[i];
                b.s  = (i == hlen);
                b.e  = (i == last - 1);
                b.em = (i == total - 1) ? em : 2'b0;
                b.er = (i == total - 1) ? er : 1'b0;
                if (total > MAX && i == last - 1) begin
                    b.er = 1'b1; b.em = 2'b0;
                end
                exp_q.push_back(b);
            end
        end
        for (int unsigned i = 0; i < total; i++)
            put(w[i], i == 0, i == total - 1, (i == total - 1) ? em : 2'b0, (i == total - 1) ? er : 1'b0);
    endtask

    task automatic test_reset;
        n_checks++;
        if ({in_ready, hdr_valid, out_valid, out_sop, out_eop, out_error, hdr_vlan_valid} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 1000000",
                     {in_ready, hdr_valid, out_valid, out_sop, out_eop, out_error, hdr_vlan_valid});
        end
        n_checks++;
        if ({hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_vlan_tci} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_hdr: got %h required 0", {hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_vlan_tci});
        end
        n_checks++;
        if ({out_data, out_empty} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h required 0", {out_data, out_empty});
        end
        n_checks++;
        if ({stat_runt_cnt, stat_trunc_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h required 0", {stat_runt_cnt, stat_trunc_cnt});
        end
    endtask

    task automatic test_basic;
        beat_t e, g;
        hdr_t eh, gh;
        send_frame(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800, 12, 2'd2, 1'b0, 8'hB1);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL basic_beat: got %h required %h", g, e); end
        end
        n_checks++;
        if (got_hdr_q.size() != exp_hdr_q.size()) begin
            n_fail++;
            $display("FAIL basic_hdrs: got %0d required %0d", got_hdr_q.size(), exp_hdr_q.size());
        end
        while (exp_hdr_q.size() > 0 && got_hdr_q.size() > 0) begin
            eh = exp_hdr_q.pop_front(); gh = got_hdr_q.pop_front(); n_checks++;
            if (gh !== eh) begin n_fail++; $display("FAIL basic_hdr: got %h required %h", gh, eh); end
        end
        exp_q.delete(); got_q.delete(); exp_hdr_q.delete(); got_hdr_q.delete();
    endtask

    task automatic test_runt;
        beat_t e, g;
        hdr_t eh, gh;
        send_frame(48'h02_00_00_00_00_0A, 48'h02_00_00_00_00_0B, 16'h0800, 0, 2'd0, 1'b0, 8'hC1);
        // abandoned partial frame followed by a restart on the next sop
        put(32'h0000_0200, 1'b1, 1'b0, 2'd0, 1'b0);
        put(32'h0000_0033, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_runt++;
        send_frame(48'h02_00_00_00_00_0C, 48'h02_00_00_00_00_0D, 16'h0806, 2, 2'd1, 1'b1, 8'hC2);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (stat_runt_cnt !== exp_runt) begin
            n_fail++;
            $display("FAIL runt_cnt: got %0d required %0d", stat_runt_cnt, exp_runt);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL runt_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL runt_beat: got %h required %h", g, e); end
        end
        n_checks++;
        if (got_hdr_q.size() != exp_hdr_q.size()) begin
            n_fail++;
            $display("FAIL runt_hdrs: got %0d required %0d", got_hdr_q.size(), exp_hdr_q.size());
        end
        while (exp_hdr_q.size() > 0 && got_hdr_q.size() > 0) begin
            eh = exp_hdr_q.pop_front(); gh = got_hdr_q.pop_front(); n_checks++;
            if (gh !== eh) begin n_fail++; $display("FAIL runt_hdr: got %h required %h", gh, eh); end
        end
        exp_q.delete(); got_q.delete(); exp_hdr_q.delete(); got_hdr_q.delete();
    endtask

    task automatic test_hdr_backpressure;
        beat_t e, g;
        hdr_t eh, gh;
        hdr_ready = 1'b0;
        fork
            begin
                send_frame(48'h02_00_00_00_01_01, 48'h02_00_00_00_01_02, 16'h0800, 4, 2'd0, 1'b0, 8'hD1);
                send_frame(48'h02_00_00_00_02_01, 48'h02_00_00_00_02_02, 16'h0801, 3, 2'd3, 1'b0, 8'hD2);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                n_checks++;
                if ({in_ready, hdr_valid} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL bp_stall: in_ready,hdr_valid=%b required 01", {in_ready, hdr_valid});
                end
                n_checks++;
                if ({hdr_dst_mac, hdr_src_mac, hdr_ethertype} !== {48'h02_00_00_00_01_01, 48'h02_00_00_00_01_02, 16'h0800}) begin
                    n_fail++;
                    $display("FAIL bp_hold: got %h required first frame header",
                             {hdr_dst_mac, hdr_src_mac, hdr_ethertype});
                end
                hdr_ready = 1'b1;
                @(posedge clk);
                #1;
                hdr_ready = 1'b0;
            end
        join
        hdr_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL bp_beat: got %h required %h", g, e); end
        end
        n_checks++;
        if (got_hdr_q.size() != exp_hdr_q.size()) begin
            n_fail++;
            $display("FAIL bp_hdrs: got %0d required %0d", got_hdr_q.size(), exp_hdr_q.size());
        end
        while (exp_hdr_q.size() > 0 && got_hdr_q.size() > 0) begin
            eh = exp_hdr_q.pop_front(); gh = got_hdr_q.pop_front(); n_checks++;
            if (gh !== eh) begin n_fail++; $display("FAIL bp_hdr: got %h required %h", gh, eh); end
        end
        exp_q.delete(); got_q.delete(); exp_hdr_q.delete(); got_hdr_q.delete();
    endtask

    task automatic test_oversize;
        beat_t e, g;
        hdr_t eh, gh;
        send_frame(48'h02_00_00_00_03_01, 48'h02_00_00_00_03_02, 16'h0800, MAX, 2'd1, 1'b0, 8'hE1);
        send_frame(48'h02_00_00_00_04_01, 48'h02_00_00_00_04_02, 16'h0800, 2, 2'd0, 1'b0, 8'hE2);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (stat_trunc_cnt !== exp_trunc) begin
            n_fail++;
            $display("FAIL trunc_cnt: got %0d required %0d", stat_trunc_cnt, exp_trunc);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL trunc_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL trunc_beat: got %h required %h", g, e); end
        end
        n_checks++;
        if (got_hdr_q.size() != exp_hdr_q.size()) begin
            n_fail++;
            $display("FAIL trunc_hdrs: got %0d required %0d", got_hdr_q.size(), exp_hdr_q.size());
        end
        while (exp_hdr_q.size() > 0 && got_hdr_q.size() > 0) begin
            eh = exp_hdr_q.pop_front(); gh = got_hdr_q.pop_front(); n_checks++;
            if (gh !== eh) begin n_fail++; $display("FAIL trunc_hdr: got %h required %h", gh, eh); end
        end
        exp_q.delete(); got_q.delete(); exp_hdr_q.delete(); got_hdr_q.delete();
    endtask

    task automatic test_vlan;
        beat_t e, g;
        hdr_t eh, gh;
        send_frame(48'h02_00_00_00_05_01, 48'h02_00_00_00_05_02, 16'h8100, 5, 2'd2, 1'b1, 8'hF1);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL vlan_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL vlan_beat: got %h required %h", g, e); end
        end
        n_checks++;
        if (got_hdr_q.size() != exp_hdr_q.size()) begin
            n_fail++;
            $display("FAIL vlan_hdrs: got %0d required %0d", got_hdr_q.size(), exp_hdr_q.size());
        end
        while (exp_hdr_q.size() > 0 && got_hdr_q.size() > 0) begin
            eh = exp_hdr_q.pop_front(); gh = got_hdr_q.pop_front(); n_checks++;
            if (gh !== eh) begin n_fail++; $display("FAIL vlan_hdr: got %h required %h", gh, eh); end
        end
        exp_q.delete(); got_q.delete(); exp_hdr_q.delete(); got_hdr_q.delete();
    endtask

    task automatic test_reset_mid;
        beat_t e, g;
        hdr_t eh, gh;
        tog_done = 1'b0;
        fork
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = ~out_ready;
                end
            end
            begin
                put(32'h0000_0200, 1'b1, 1'b0, 2'd0, 1'b0);
                put(32'h0000_0601, 1'b0, 1'b0, 2'd0, 1'b0);
                put(32'h0200_0000, 1'b0, 1'b0, 2'd0, 1'b0);
                put(32'h0602_0800, 1'b0, 1'b0, 2'd0, 1'b0);
                eh.dst = 48'h02_00_00_00_06_01; eh.src = 48'h02_00_00_00_06_02;
                eh.typ = 16'h0800; eh.tci = 16'h0; eh.vv = 1'b0;
                exp_hdr_q.push_back(eh);
                for (int unsigned i = 0; i < 3; i++) begin
                    put(32'h7700_0000 + i, 1'b0, 1'b0, 2'd0, 1'b0);
                    e.d = 32'h7700_0000 + i; e.s = (i == 0); e.e = 1'b0; e.em = 2'd0; e.er = 1'b0;
                    exp_q.push_back(e);
                end
                tog_done = 1'b1;
            end
        join
        in_data = 32'h7700_0003; in_valid = 1'b1; out_ready = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_runt = 16'h0;
        exp_trunc = 16'h0;
        n_checks++;
        if ({in_ready, hdr_valid, out_valid, out_sop, out_eop, out_error} !== 6'b100000) begin
            n_fail++;
            $display("FAIL rstmid_flags: got %b required 100000",
                     {in_ready, hdr_valid, out_valid, out_sop, out_eop, out_error});
        end
        n_checks++;
        if ({hdr_dst_mac, stat_runt_cnt, stat_trunc_cnt, out_data} !== 112'h0) begin
            n_fail++;
            $display("FAIL rstmid_regs: got %h required 0", {hdr_dst_mac, stat_runt_cnt, stat_trunc_cnt, out_data});
        end
        in_valid = 1'b0;
        send_frame(48'h02_00_00_00_07_01, 48'h02_00_00_00_07_02, 16'h0800, 3, 2'd1, 1'b0, 8'h91);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rstmid_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rstmid_beat: got %h required %h", g, e); end
        end
        n_checks++;
        if (got_hdr_q.size() != exp_hdr_q.size()) begin
            n_fail++;
            $display("FAIL rstmid_hdrs: got %0d required %0d", got_hdr_q.size(), exp_hdr_q.size());
        end
        while (exp_hdr_q.size() > 0 && got_hdr_q.size() > 0) begin
            eh = exp_hdr_q.pop_front(); gh = got_hdr_q.pop_front(); n_checks++;
            if (gh !== eh) begin n_fail++; $display("FAIL rstmid_hdr: got %h required %h", gh, eh); end
        end
        exp_q.delete(); got_q.delete(); exp_hdr_q.delete(); got_hdr_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_data = 32'h0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_empty = 2'b0; in_error = 1'b0;
        out_ready = 1'b1; hdr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_basic;
        test_runt;
        test_hdr_backpressure;
        test_oversize;
        test_vlan;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rx_hdr_parser.md
# eth_rx_hdr_parser

Consumes the MAC RX Avalon-ST stream (32-bit, RX_SHIFT16 enabled so the two pad bytes lead the frame) and splits each frame into a header record and a payload stream. The header record (destination MAC, source MAC, EtherType) goes to the load-balancer lookup logic. The payload, starting at the L3 header, is forwarded word-aligned to the downstream rewrite/TX path. Runt and oversize frames are detected, counted and dropped or truncated here.

## Interface
- MAX_FRAME_WORDS, 384 — longest accepted frame in 32-bit words, including the pad and L2 header words; longer frames are truncated.
- clk  in  1  system clock (sys_clk domain)
- rst  in  1  synchronous, active-high reset
- in_data  in  32  RX word; byte 0 in [31:24]
- in_valid  in  1  RX word valid
- in_ready  out  1  RX backpressure
- in_sop / in_eop  in  1  start / end of frame
- in_empty  in  2  empty bytes on the eop word
- in_error  in  1  OR of the MAC error bits, valid on eop
- hdr_dst_mac  out  48  destination MAC
- hdr_src_mac  out  48  source MAC
- hdr_ethertype  out  16  EtherType (inner type when a VLAN tag is stripped)
- hdr_vlan_tci  out  16  802.1Q TCI, 0 if untagged
- hdr_vlan_valid  out  1  frame carried an 802.1Q tag
- hdr_valid / hdr_ready  out/in  1  header record handshake
- out_data  out  32  payload word
- out_valid / out_ready  out/in  1  payload handshake
- out_sop / out_eop  out  1  payload framing
- out_empty  out  2  empty bytes on the payload eop word
- out_error  out  1  error flag, valid on eop
- stat_runt_cnt  out  16  saturating count of dropped runt frames
- stat_trunc_cnt  out  16  saturating count of truncated frames

## Operation
- **Word layout:**
  - W0 = pad, pad, dst0, dst1
  - W1 = dst2..dst5
  - W2 = src0..src3
  - W3 = src4, src5, type0, type1
  - W4 and later = payload
- **FSM states:** IDLE, HDR1, HDR2, HDR3, [VLAN], PAYLOAD, DROP.
- **IDLE:** accepts a word only when in_sop=1; other words are consumed and discarded. On sop, it latches the dst high half and moves to HDR1.
- **HDR1 and HDR2:** latch fields, one word each.
- **HDR3:**
  - in_ready = !hdr_valid, so a pending header is never overwritten.
  - On acceptance, latches src low / type.
  - If type ≠ 0x8100, or VLAN support is compiled out: hdr_valid←1 and move to PAYLOAD.
- **VLAN** (compiled in only):
  - W4 = TCI[15:8], TCI[7:0], type0, type1.
  - Latches the TCI and the inner type, sets hdr_vlan_valid=1 and hdr_valid←1, then moves to PAYLOAD.
- **PAYLOAD:** combinational pass-through.
  - out_valid = in_valid, in_ready = out_ready, out_data/out_empty/out_error follow the input.
  - out_sop=1 on the first payload word only.
  - out_eop = in_eop, returning to IDLE.
- **Header handshake:** hdr_valid is cleared by hdr_valid && hdr_ready. Payload forwarding does not wait for the header handshake.
- **Runt:** in_eop on any word up to and including the last header word means no payload.
  - Nothing is emitted; hdr_valid is not set.
  - stat_runt_cnt increments; the FSM returns to IDLE.
- **sop during HDR states:** the frame so far is abandoned, counted as a runt, and parsing restarts with the current word as W0.
- **sop during PAYLOAD:** ignored and forwarded as data; out_sop is generated only by this block.
- **Truncation:**
  - A word counter counts all accepted words of the frame.
  - When the counter reaches MAX_FRAME_WORDS without in_eop, that word is forwarded with out_eop=1, out_error=1 and out_empty=0.
  - stat_trunc_cnt increments and the FSM moves to DROP.
- **DROP:** in_ready=1 and out_valid=0. Words are discarded until in_eop, then the FSM returns to IDLE.
- **Counters:** both saturate at 0xFFFF.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - in_ready=1.
  - hdr_valid, out_valid, out_sop, out_eop, out_error, hdr_vlan_valid = 0.
  - All header fields, out_data, out_empty and both counters = 0.
- **Header latency:** hdr_valid rises the cycle after W3 is accepted (W4 when tagged).
- **Payload latency:** zero cycles; out_* is combinational from in_* in PAYLOAD.
- **Ordering:** the first payload word can be accepted in the cycle after W3/W4.
- **Stability:** header fields are held stable while hdr_valid=1.
- **Reset mid-frame:** everything returns to IDLE in the next cycle, and hdr_valid/out_valid drop with no eop emitted. Downstream must tolerate this.
- **Simultaneous hdr_ready and header completion:** the old record is consumed and the new one is loaded in the same edge.

## Configuration
- **ETH_RX_HDR_VLAN_EN defined:** 802.1Q single-tag stripping is enabled, using the VLAN state described above.
- **Undefined:**
  - The VLAN state is absent.
  - hdr_vlan_tci = 0 and hdr_vlan_valid = 0 constantly.
  - 0x8100 is reported as the EtherType, and the tag bytes appear as the first payload word.

## Test plan
- **Basic frame:** 16-word frame, dst 02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800 → one header with those values; 12 payload words, out_sop on the first, out_eop on the last, out_empty copied from the input.
- **Runt:** sop on W0, eop on W3 → no hdr_valid, no out_valid, stat_runt_cnt=1.
- **Header backpressure:** hdr_ready=0; two back-to-back frames → second frame stalls at HDR3 (in_ready=0) until hdr_ready pulses; first header values held unchanged.
- **Oversize:** MAX_FRAME_WORDS=8, 12-word frame → 4 payload words, the last with out_eop=1 and out_error=1; remaining words dropped; stat_trunc_cnt=1; next frame parses normally.
- **VLAN:** with ETH_RX_HDR_VLAN_EN, type 0x8100, TCI 0x0064, inner type 0x86DD → hdr_vlan_valid=1, hdr_vlan_tci=0x0064, hdr_ethertype=0x86DD; payload starts at W5.
- **Reset mid-frame:** rst asserted during PAYLOAD with out_ready toggling → all outputs at reset values the next cycle; a following frame parses correctly.
